// File: rtl/core_pkg.sv
// Shared RV32I core definitions: widths, ALU select codes and control-bit positions.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'd0,
    ALU_SLL     = 3'd1,
    ALU_SLT     = 3'd2,
    ALU_SLTU    = 3'd3,
    ALU_XOR     = 3'd4,
    ALU_SRL_SRA = 3'd5,
    ALU_OR      = 3'd6,
    ALU_AND     = 3'd7
  } alu_sel_e;

  // rotate doubles as the arithmetic-shift flag when sel is ALU_SRL_SRA
  typedef struct packed {
    logic     rotate;
    alu_sel_e sel;
  } alu_op_t;

  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;
  localparam int OP1_PC_BIT    = 1;
  localparam int OP2_IMM_BIT   = 0;

endpackage

// File: rtl/operand_forward_unit.sv
// Three-way operand bypass: EX/MEM result, then MEM/WB result, then the registered value.
module operand_forward_unit
  import core_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [ADDR_W-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic [ADDR_W-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_data
);

  // x0 is hardwired to zero, so a zero destination never produces a bypass
  always_comb begin
    o_data = i_rs_data;
    if (i_rs_addr != '0 && i_rs_addr == i_exmem_rd) begin
      o_data = i_exmem_result;
    end else if (i_rs_addr != '0 && i_rs_addr == i_memwb_rd) begin
      o_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// downstream hold and branch flush; feeds the integer ALU directly.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [XLEN-1:0]       i_id_pc,
  input  logic [XLEN-1:0]       i_id_rs1_data,
  input  logic [XLEN-1:0]       i_id_rs2_data,
  input  logic [XLEN-1:0]       i_id_imm,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic [1:0]            i_id_op_sel,
  input  logic [3:0]            i_id_alu_op,
  input  logic [1:0]            i_id_mem_ctrl,
  input  logic                  i_flush,
  input  logic                  i_hold,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]       i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]       i_memwb_result,
  output logic                  o_stall_out,
  output logic                  o_ex_valid,
  output logic [XLEN-1:0]       o_alu_data1,
  output logic [XLEN-1:0]       o_alu_data2,
  output logic [2:0]            o_alu_select,
  output logic                  o_alu_rotate,
  output logic [XLEN-1:0]       o_ex_store_data,
  output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
  output logic [1:0]            o_ex_mem_ctrl
);
  import core_pkg::*;

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_op_sel;
  alu_op_t               r_alu_op;
  logic [1:0]            r_mem_ctrl;

  logic [XLEN-1:0]       w_fwd_rs1;
  logic [XLEN-1:0]       w_fwd_rs2;
  logic                  w_rs1_hit;
  logic                  w_rs2_hit;
  logic                  w_load_use;

  // A store always reads rs2 even though op2 is the immediate
  assign w_rs1_hit  = (i_id_rs1_addr == r_rd) && !i_id_op_sel[OP1_PC_BIT];
  assign w_rs2_hit  = (i_id_rs2_addr == r_rd) &&
                      (!i_id_op_sel[OP2_IMM_BIT] || i_id_mem_ctrl[MEM_WRITE_BIT]);
  assign w_load_use = r_valid && r_mem_ctrl[MEM_READ_BIT] && (r_rd != '0) &&
                      i_id_valid && (w_rs1_hit || w_rs2_hit);

  assign o_stall_out = !i_flush && (i_hold || w_load_use);

  operand_forward_unit #(.DATA_W(XLEN), .ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs_addr      (r_rs1_addr),
    .i_rs_data      (r_rs1_data),
    .i_exmem_rd     (i_exmem_rd),
    .i_exmem_result (i_exmem_result),
    .i_memwb_rd     (i_memwb_rd),
    .i_memwb_result (i_memwb_result),
    .o_data         (w_fwd_rs1)
  );

  operand_forward_unit #(.DATA_W(XLEN), .ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs_addr      (r_rs2_addr),
    .i_rs_data      (r_rs2_data),
    .i_exmem_rd     (i_exmem_rd),
    .i_exmem_result (i_exmem_result),
    .i_memwb_rd     (i_memwb_rd),
    .i_memwb_result (i_memwb_result),
    .o_data         (w_fwd_rs2)
  );

  // Reset, flush, load-use and an empty decode slot all leave an all-zero bubble.
  // Under hold the operands absorb the bypass so a retiring producer is not lost.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd       <= '0;
      r_op_sel   <= '0;
      r_alu_op   <= '0;
      r_mem_ctrl <= '0;
    end else if (i_hold) begin
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else if (w_load_use || !i_id_valid) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd       <= '0;
      r_op_sel   <= '0;
      r_alu_op   <= '0;
      r_mem_ctrl <= '0;
    end else begin
      r_valid    <= 1'b1;
      r_pc       <= i_id_pc;
      r_rs1_data <= i_id_rs1_data;
      r_rs2_data <= i_id_rs2_data;
      r_imm      <= i_id_imm;
      r_rs1_addr <= i_id_rs1_addr;
      r_rs2_addr <= i_id_rs2_addr;
      r_rd       <= i_id_rd_addr;
      r_op_sel   <= i_id_op_sel;
      r_alu_op   <= alu_op_t'(i_id_alu_op);
      r_mem_ctrl <= i_id_mem_ctrl;
    end
  end

  assign o_ex_valid      = r_valid;
  assign o_alu_data1     = r_op_sel[OP1_PC_BIT]  ? r_pc  : w_fwd_rs1;
  assign o_alu_data2     = r_op_sel[OP2_IMM_BIT] ? r_imm : w_fwd_rs2;
  assign o_alu_select    = r_alu_op.sel;
  assign o_alu_rotate    = r_alu_op.rotate;
  assign o_ex_store_data = w_fwd_rs2;
  assign o_ex_rd_addr    = r_rd;
  assign o_ex_mem_ctrl   = r_mem_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use bubble, hold, flush and reset.
module tb_id_ex_stage;

  logic        clock;
  logic        reset;
  logic        idValid;
  logic [31:0] idPc, idRs1Data, idRs2Data, idImm;
  logic [4:0]  idRs1Addr, idRs2Addr, idRdAddr;
  logic [1:0]  idOpSel;
  logic [3:0]  idAluOp;
  logic [1:0]  idMemCtrl;
  logic        flush, hold;
  logic [4:0]  exmemRd, memwbRd;
  logic [31:0] exmemResult, memwbResult;
  logic        stallOut, exValid, aluRotate;
  logic [31:0] aluData1, aluData2, exStoreData;
  logic [2:0]  aluSelect;
  logic [4:0]  exRdAddr;
  logic [1:0]  exMemCtrl;

  int nChecks = 0;
  int nFails  = 0;

  id_ex_stage dut (
    .i_clk           (clock),
    .i_reset         (reset),
    .i_id_valid      (idValid),
    .i_id_pc         (idPc),
    .i_id_rs1_data   (idRs1Data),
    .i_id_rs2_data   (idRs2Data),
    .i_id_imm        (idImm),
    .i_id_rs1_addr   (idRs1Addr),
    .i_id_rs2_addr   (idRs2Addr),
    .i_id_rd_addr    (idRdAddr),
    .i_id_op_sel     (idOpSel),
    .i_id_alu_op     (idAluOp),
    .i_id_mem_ctrl   (idMemCtrl),
    .i_flush         (flush),
    .i_hold          (hold),
    .i_exmem_rd      (exmemRd),
    .i_exmem_result  (exmemResult),
    .i_memwb_rd      (memwbRd),
    .i_memwb_result  (memwbResult),
    .o_stall_out     (stallOut),
    .o_ex_valid      (exValid),
    .o_alu_data1     (aluData1),
    .o_alu_data2     (aluData2),
    .o_alu_select    (aluSelect),
    .o_alu_rotate    (aluRotate),
    .o_ex_store_data (exStoreData),
    .o_ex_rd_addr    (exRdAddr),
    .o_ex_mem_ctrl   (exMemCtrl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] rs1d,
                               input logic [31:0] rs2d, input logic [31:0] imm,
                               input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rd,
                               input logic [1:0] opSel, input logic [3:0] aluOp,
                               input logic [1:0] memCtrl);
    idValid   = v;
    idPc      = pc;
    idRs1Data = rs1d;
    idRs2Data = rs2d;
    idImm     = imm;
    idRs1Addr = rs1a;
    idRs2Addr = rs2a;
    idRdAddr  = rd;
    idOpSel   = opSel;
    idAluOp   = aluOp;
    idMemCtrl = memCtrl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, "_valid"}, 32'(exValid), 32'd0);
    checkOutput({tag, "_rd"}, 32'(exRdAddr), 32'd0);
    checkOutput({tag, "_memctrl"}, 32'(exMemCtrl), 32'd0);
    checkOutput({tag, "_select"}, 32'(aluSelect), 32'd0);
    checkOutput({tag, "_rotate"}, 32'(aluRotate), 32'd0);
    checkOutput({tag, "_data1"}, aluData1, 32'd0);
    checkOutput({tag, "_data2"}, aluData2, 32'd0);
    checkOutput({tag, "_store"}, exStoreData, 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    exmemRd = '0; exmemResult = '0; memwbRd = '0; memwbResult = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'b00, 4'h0, 2'b00);
    tick();
    tick();
    checkBubble("reset");
    checkOutput("reset_stall", 32'(stallOut), 32'd0);
    reset = 1'b0;

    // ADD x3,x1,x2
    applyStimulus(1'b1, 32'h100, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 2'b00, 4'h0, 2'b00);
    #1;
    checkOutput("add_stall", 32'(stallOut), 32'd0);
    tick();
    checkOutput("add_valid", 32'(exValid), 32'd1);
    checkOutput("add_data1", aluData1, 32'd5);
    checkOutput("add_data2", aluData2, 32'd7);
    checkOutput("add_select", 32'(aluSelect), 32'd0);
    checkOutput("add_rd", 32'(exRdAddr), 32'd3);

    // Bypass priority on rs1=x1 while ADD sits in EX; next ID is SRAI-like x7,x0
    applyStimulus(1'b1, 32'h104, 32'h1234, 32'h77, 32'hFFFF_FFF0, 5'd0, 5'd0, 5'd7, 2'b01, 4'hD, 2'b00);
    exmemRd = 5'd1; exmemResult = 32'h11; memwbRd = 5'd1; memwbResult = 32'h22;
    #1;
    checkOutput("fwd_exmem_wins", aluData1, 32'h11);
    checkOutput("fwd_rs2_none", exStoreData, 32'd7);
    exmemRd = 5'd0;
    #1;
    checkOutput("fwd_memwb", aluData1, 32'h22);
    memwbRd = 5'd0;
    tick();
    exmemResult = 32'h55; memwbResult = 32'h66;
    #1;
    checkOutput("x0_data1", aluData1, 32'h1234);
    checkOutput("x0_store", exStoreData, 32'h77);
    checkOutput("imm_data2", aluData2, 32'hFFFF_FFF0);
    checkOutput("sra_select", 32'(aluSelect), 32'd5);
    checkOutput("sra_rotate", 32'(aluRotate), 32'd1);
    checkOutput("sra_rd", 32'(exRdAddr), 32'd7);
    exmemResult = 32'h0; memwbResult = 32'h0;

    // AUIPC x11: PC and immediate operands
    applyStimulus(1'b1, 32'h200, 32'h0, 32'h0, 32'h1000, 5'd0, 5'd0, 5'd11, 2'b11, 4'h0, 2'b00);
    tick();
    checkOutput("auipc_data1", aluData1, 32'h200);
    checkOutput("auipc_data2", aluData2, 32'h1000);

    // LW x4,8(x1) then dependent ADD x5,x4,x1
    applyStimulus(1'b1, 32'h108, 32'h1000, 32'h0, 32'd8, 5'd1, 5'd0, 5'd4, 2'b01, 4'h0, 2'b10);
    tick();
    checkOutput("lw_memctrl", 32'(exMemCtrl), 32'd2);
    checkOutput("lw_data2", aluData2, 32'd8);
    applyStimulus(1'b1, 32'h10C, 32'hBAD, 32'h1000, 32'h0, 5'd4, 5'd1, 5'd5, 2'b00, 4'h0, 2'b00);
    #1;
    checkOutput("loaduse_stall", 32'(stallOut), 32'd1);
    tick();
    checkBubble("loaduse_bubble");
    checkOutput("loaduse_stall_once", 32'(stallOut), 32'd0);
    exmemRd = 5'd4; exmemResult = 32'hCAFE;
    tick();
    checkOutput("after_lw_valid", 32'(exValid), 32'd1);
    checkOutput("after_lw_rd", 32'(exRdAddr), 32'd5);
    checkOutput("after_lw_data1", aluData1, 32'hCAFE);
    checkOutput("after_lw_data2", aluData2, 32'h1000);
    exmemRd = 5'd0; exmemResult = 32'h0;

    // SW x6,4(x2) held three cycles; x6 retires from MEM/WB only in the first
    applyStimulus(1'b1, 32'h110, 32'h2000, 32'h1, 32'd4, 5'd2, 5'd6, 5'd0, 2'b01, 4'h0, 2'b01);
    tick();
    checkOutput("sw_store_stale", exStoreData, 32'h1);
    applyStimulus(1'b1, 32'h114, 32'h3, 32'h3, 32'h0, 5'd3, 5'd3, 5'd9, 2'b00, 4'h0, 2'b00);
    hold = 1'b1; memwbRd = 5'd6; memwbResult = 32'h99;
    #1;
    checkOutput("hold_stall", 32'(stallOut), 32'd1);
    checkOutput("hold_store_c1", exStoreData, 32'h99);
    tick();
    memwbRd = 5'd0; memwbResult = 32'h0;
    #1;
    checkOutput("hold_store_c2", exStoreData, 32'h99);
    checkOutput("hold_memctrl", 32'(exMemCtrl), 32'd1);
    checkOutput("hold_data2", aluData2, 32'd4);
    checkOutput("hold_stall_c2", 32'(stallOut), 32'd1);
    tick();
    checkOutput("hold_store_c3", exStoreData, 32'h99);
    tick();
    hold = 1'b0;
    applyStimulus(1'b1, 32'h118, 32'h2000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd8, 2'b01, 4'h0, 2'b10);
    #1;
    checkOutput("release_store", exStoreData, 32'h99);
    checkOutput("release_valid", 32'(exValid), 32'd1);
    checkOutput("release_stall", 32'(stallOut), 32'd0);

    // LW x8 in EX: immediate-only consumer does not stall, rs1 consumer does, flush overrides
    tick();
    checkOutput("lw8_rd", 32'(exRdAddr), 32'd8);
    applyStimulus(1'b1, 32'h11C, 32'h1, 32'h0, 32'd8, 5'd1, 5'd8, 5'd10, 2'b01, 4'h0, 2'b00);
    #1;
    checkOutput("imm_no_stall", 32'(stallOut), 32'd0);
    applyStimulus(1'b1, 32'h11C, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0, 5'd10, 2'b00, 4'h0, 2'b00);
    hold = 1'b1;
    #1;
    checkOutput("hazard_stall", 32'(stallOut), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", 32'(stallOut), 32'd0);
    tick();
    checkOutput("flush_valid", 32'(exValid), 32'd0);
    checkOutput("flush_rd", 32'(exRdAddr), 32'd0);
    checkOutput("flush_memctrl", 32'(exMemCtrl), 32'd0);
    flush = 1'b0; hold = 1'b0;

    // SW x6,12(x2) held, then reset
    applyStimulus(1'b1, 32'h120, 32'h3000, 32'h55, 32'd12, 5'd2, 5'd6, 5'd0, 2'b01, 4'h0, 2'b01);
    tick();
    checkOutput("sw2_store", exStoreData, 32'h55);
    hold = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checkBubble("midhold_reset");
    hold = 1'b0;
    #1;
    checkOutput("midhold_reset_stall", 32'(stallOut), 32'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name:
id_ex_stage

Overview:
ID/EX pipeline register of the RV32I core; sits directly upstream of the 32-bit integer ALU and drives its DATA1/DATA2/SELECT/ROTATE inputs. Captures decoded operands and control each cycle, applies EX/MEM and MEM/WB forwarding, detects load-use hazards (inserting bubbles), and honours downstream hold and branch flush.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register-address width

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous reset, active-high
ID_VALID  in  1  decode slot holds a real instruction
ID_PC  in  XLEN  PC of decode instruction
ID_RS1_DATA  in  XLEN  register-file rs1 value
ID_RS2_DATA  in  XLEN  register-file rs2 value
ID_IMM  in  XLEN  sign-extended immediate
ID_RS1_ADDR  in  REG_ADDR_W  rs1 index
ID_RS2_ADDR  in  REG_ADDR_W  rs2 index
ID_RD_ADDR  in  REG_ADDR_W  destination; 0 = no writeback
ID_OP_SEL  in  2  [1]=op1 is PC (else rs1), [0]=op2 is IMM (else rs2)
ID_ALU_OP  in  4  {rotate, select[2:0]} ALU opcode
ID_MEM_CTRL  in  2  {mem_read, mem_write}
FLUSH  in  1  branch taken: kill EX and decode instructions
HOLD  in  1  downstream stall: freeze this stage
EXMEM_RD  in  REG_ADDR_W  EX/MEM destination; 0 = none
EXMEM_RESULT  in  XLEN  EX/MEM result
MEMWB_RD  in  REG_ADDR_W  MEM/WB destination; 0 = none
MEMWB_RESULT  in  XLEN  MEM/WB writeback value
STALL_OUT  out  1  freeze PC and IF/ID (combinational)
EX_VALID  out  1  EX slot holds a real instruction
ALU_DATA1  out  XLEN  forwarded operand 1
ALU_DATA2  out  XLEN  forwarded operand 2 or IMM
ALU_SELECT  out  3  ALU select code
ALU_ROTATE  out  1  ALU shift-arithmetic flag
EX_STORE_DATA  out  XLEN  forwarded rs2 for stores
EX_RD_ADDR  out  REG_ADDR_W  destination, 0 for bubble
EX_MEM_CTRL  out  2  {mem_read, mem_write}, 0 for bubble

Behaviour:
- Reset (sync, highest priority): all registered fields cleared; EX_VALID=0, EX_RD_ADDR=0, EX_MEM_CTRL=0, ALU_SELECT=0, ALU_ROTATE=0, ALU_DATA1/2=0, EX_STORE_DATA=0. Reset mid-hazard drops the hazard.
- Load-use: load_use = EX_VALID & EX_MEM_CTRL[1] & EX_RD_ADDR!=0 & ID_VALID & ((ID_RS1_ADDR==EX_RD_ADDR & !ID_OP_SEL[1]) | (ID_RS2_ADDR==EX_RD_ADDR & (!ID_OP_SEL[0] | ID_MEM_CTRL[0]))).
- STALL_OUT = !FLUSH & (HOLD | load_use).
- Posedge priority: RESET > FLUSH (load bubble) > HOLD (keep slot, refresh operands) > load_use (load bubble) > capture ID fields (EX_VALID=ID_VALID; if !ID_VALID, capture as bubble).
- Bubble: VALID=0, RD=0, MEM_CTRL=0, ALU op=0 (ADD), data=0. One load-use bubble per hazard; the next cycle the load sits in EX/MEM and forwards normally.
- Forwarding (combinational from registered rs values): if rs!=0 & rs==EXMEM_RD, use EXMEM_RESULT; else if rs!=0 & rs==MEMWB_RD, use MEMWB_RESULT; else use the registered value. x0 is never forwarded. EX/MEM wins when both match.
- ALU_DATA1 = op1 PC ? PC : fwd_rs1; ALU_DATA2 = op2 IMM ? IMM : fwd_rs2; EX_STORE_DATA = fwd_rs2 always.
- HOLD: registered rs1/rs2 are overwritten with fwd_rs1/fwd_rs2 every held cycle, so a producer retiring during the hold is not lost. Control fields are unchanged.
- Latency: one cycle from ID to ALU inputs; zero-cycle forwarding.

Decomposition:
- Shared package core_pkg: ALU_ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND=7; MEM_CTRL bit positions; OP_SEL bit positions; XLEN/REG_ADDR_W constants.
- One sub-module, operand_forward_unit: a combinational 3-way forwarding mux, instantiated twice (rs1, rs2).

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, no hazards → next cycle ALU_DATA1=5, ALU_DATA2=7, ALU_SELECT=0, EX_RD_ADDR=3, EX_VALID=1.
- EXMEM_RD=1/EXMEM_RESULT=0x11 and MEMWB_RD=1/MEMWB_RESULT=0x22 while EX rs1=x1 → ALU_DATA1=0x11. With EXMEM_RD=0: ALU_DATA1=0x22. With rs1=x0 and both RDs=0: ALU_DATA1=registered value.
- LW x4 in EX, then ADD x5,x4,x1 in ID → STALL_OUT=1 for one cycle, next EX_VALID=0 and EX_MEM_CTRL=0; following cycle ADD enters EX with x4 forwarded from EXMEM_RESULT.
- HOLD=1 for 3 cycles while EX rs2=x6 and MEMWB_RD=6/RESULT=0x99 in cycle 1 only → EX_STORE_DATA=0x99 throughout the hold and after release; STALL_OUT=1 while held.
- FLUSH=1 together with HOLD=1 and load_use=1 → STALL_OUT=0; next cycle EX_VALID=0, EX_RD_ADDR=0, EX_MEM_CTRL=0.
- RESET asserted mid-hold with a valid store in EX → next cycle all outputs 0 and EX_VALID=0.
